// File: rtl/smart_house_uart_rx.sv
// smart_house_uart_rx: 8N1 UART receiver feeding the SmartHouse command
// recogniser. Each good byte appears on char with a one-cycle char_valid.
// Define SMART_HOUSE_UART_PARITY_EN for 8E1 framing with a parity_error pulse.
module smart_house_uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] char,
    output logic       char_valid,
    output logic       frame_error,
    output logic       busy
`ifdef SMART_HOUSE_UART_PARITY_EN
    ,
    output logic       parity_error
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SMART_HOUSE_UART_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state, state_n;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    char_n;
    logic          char_valid_n, frame_error_n;
`ifdef SMART_HOUSE_UART_PARITY_EN
    logic          par, par_n;
    logic          parity_error_n;
`endif

    assign busy = (state != IDLE);

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and datapath updates; every sample point is mid-bit.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        bit_idx_n     = bit_idx;
        shift_n       = shift;
        char_n        = char;
        char_valid_n  = 1'b0;
        frame_error_n = 1'b0;
`ifdef SMART_HOUSE_UART_PARITY_EN
        par_n          = par;
        parity_error_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n   = DATA;
                        bit_idx_n = 3'd0;
                    end else begin
                        state_n = IDLE;   // glitch, not a start bit
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_n            = '0;
                    shift_n[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
`ifdef SMART_HOUSE_UART_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef SMART_HOUSE_UART_PARITY_EN
            PARITY: begin
                if (cnt == FULL_M1) begin
                    cnt_n   = '0;
                    par_n   = rx_s;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
`ifdef SMART_HOUSE_UART_PARITY_EN
                        if (^{shift, par}) begin
                            parity_error_n = 1'b1;
                        end else begin
                            char_n       = shift;
                            char_valid_n = 1'b1;
                        end
`else
                        char_n       = shift;
                        char_valid_n = 1'b1;
`endif
                    end else begin
                        // Stop bit low wins over any parity result.
                        frame_error_n = 1'b1;
                        state_n       = WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath and strobe registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            bit_idx      <= 3'd0;
            shift        <= 8'h00;
            char         <= 8'h00;
            char_valid   <= 1'b0;
            frame_error  <= 1'b0;
`ifdef SMART_HOUSE_UART_PARITY_EN
            par          <= 1'b0;
            parity_error <= 1'b0;
`endif
        end else begin
            cnt          <= cnt_n;
            bit_idx      <= bit_idx_n;
            shift        <= shift_n;
            char         <= char_n;
            char_valid   <= char_valid_n;
            frame_error  <= frame_error_n;
`ifdef SMART_HOUSE_UART_PARITY_EN
            par          <= par_n;
            parity_error <= parity_error_n;
`endif
        end
    end

endmodule

// File: tb/tb_smart_house_uart_rx.sv
// Directed bench for smart_house_uart_rx at CLKS_PER_BIT=8.
// Also covers 8E1 framing when SMART_HOUSE_UART_PARITY_EN is defined.
module tb_smart_house_uart_rx;

    localparam int CPB = 8;
`ifdef SMART_HOUSE_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] char;
    logic       char_valid;
    logic       frame_error;
    logic       busy;
`ifdef SMART_HOUSE_UART_PARITY_EN
    logic       parity_error;
    logic       par_flip = 1'b0;
    int         pe_cnt = 0;
`endif

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int cvbusy_cnt = 0;
    int busy_seen = 0;
    logic [7:0] q_char[$];
    int         q_cyc[$];

    smart_house_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .char        (char),
        .char_valid  (char_valid),
        .frame_error (frame_error),
        .busy        (busy)
`ifdef SMART_HOUSE_UART_PARITY_EN
        ,
        .parity_error(parity_error)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Event recorder, sampled on the falling edge.
    always @(negedge clock) begin
        if (char_valid) begin
            cv_cnt++;
            q_char.push_back(char);
            q_cyc.push_back(cyc);
        end
        if (frame_error) fe_cnt++;
        if (char_valid && frame_error) both_cnt++;
        if (char_valid && busy) cvbusy_cnt++;
        if (busy) busy_seen = 1;
`ifdef SMART_HOUSE_UART_PARITY_EN
        if (parity_error) pe_cnt++;
        if (parity_error && (char_valid || frame_error)) both_cnt++;
`endif
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef SMART_HOUSE_UART_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clock);
        total++; if (char !== 8'h00) begin bad++; $display("FAIL reset_char got=%h exp=00", char); end
        total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL reset_cv got=%b exp=0", char_valid); end
        total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b exp=0", frame_error); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b1;
        idle(5);
    endtask

    task automatic test_single();
        int cv0 = cv_cnt;
        int fe0 = fe_cnt;
        send_frame(8'h4F, 1'b1);
        idle(4);
        total++; if (cv_cnt - cv0 !== 1) begin bad++; $display("FAIL single_cv_count got=%0d exp=1", cv_cnt - cv0); end
        total++; if (char !== 8'h4F) begin bad++; $display("FAIL single_char got=%h exp=4f", char); end
        total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL single_fe got=%0d exp=0", fe_cnt - fe0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_c[4];
        int base = q_char.size();
        int cv0 = cv_cnt;
        exp_c[0] = 8'h4F; exp_c[1] = 8'h50; exp_c[2] = 8'h45; exp_c[3] = 8'h4E;
        for (int i = 0; i < 4; i++) send_frame(exp_c[i], 1'b1);
        idle(4);
        total++;
        if (cv_cnt - cv0 !== 4) begin
            bad++; $display("FAIL b2b_cv_count got=%0d exp=4", cv_cnt - cv0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (q_char[base+i] !== exp_c[i]) begin
                    bad++; $display("FAIL b2b_char%0d got=%h exp=%h", i, q_char[base+i], exp_c[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                total++;
                if (q_cyc[base+i] - q_cyc[base+i-1] !== CPB * FRAME_BITS) begin
                    bad++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i,
                                    q_cyc[base+i] - q_cyc[base+i-1], CPB * FRAME_BITS);
                end
            end
        end
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL b2b_cv_fe_overlap got=%0d exp=0", both_cnt); end
        total++; if (cvbusy_cnt !== 0) begin bad++; $display("FAIL b2b_cv_busy_overlap got=%0d exp=0", cvbusy_cnt); end
    endtask

    task automatic test_glitch();
        int cv0 = cv_cnt;
        int fe0 = fe_cnt;
        busy_seen = 0;
        rx = 1'b0;
        repeat (2) @(negedge clock);
        idle(12);
        total++; if (busy_seen !== 1) begin bad++; $display("FAIL glitch_busy_seen got=%0d exp=1", busy_seen); end
        total++; if (cv_cnt - cv0 !== 0) begin bad++; $display("FAIL glitch_cv got=%0d exp=0", cv_cnt - cv0); end
        total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL glitch_fe got=%0d exp=0", fe_cnt - fe0); end
        total++; if (char !== 8'h4E) begin bad++; $display("FAIL glitch_char got=%h exp=4e", char); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_frame_error();
        int cv0 = cv_cnt;
        int fe0 = fe_cnt;
        send_frame(8'h57, 1'b0);
        rx = 1'b0;
        repeat (30) @(negedge clock);
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt - fe0); end
        total++; if (cv_cnt - cv0 !== 0) begin bad++; $display("FAIL ferr_cv got=%0d exp=0", cv_cnt - cv0); end
        total++; if (char !== 8'h4E) begin bad++; $display("FAIL ferr_char_held got=%h exp=4e", char); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_wait_high_busy got=%b exp=1", busy); end
        idle(6);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_release_busy got=%b exp=0", busy); end
        send_frame(8'h44, 1'b1);
        idle(4);
        total++; if (char !== 8'h44) begin bad++; $display("FAIL ferr_next_char got=%h exp=44", char); end
        total++; if (cv_cnt - cv0 !== 1) begin bad++; $display("FAIL ferr_next_cv got=%0d exp=1", cv_cnt - cv0); end
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL ferr_total_fe got=%0d exp=1", fe_cnt - fe0); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] d = 8'h49;
        int cv0 = cv_cnt;
        int fe0 = fe_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        repeat (4) @(negedge clock);
        reset = 1'b0;
        rx    = 1'b1;
        @(negedge clock);
        total++; if (char !== 8'h00) begin bad++; $display("FAIL abort_char_reset got=%h exp=00", char); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy_reset got=%b exp=0", busy); end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        idle(20);
        total++; if (cv_cnt - cv0 !== 0) begin bad++; $display("FAIL abort_no_strobe got=%0d exp=0", cv_cnt - cv0); end
        total++; if (char !== 8'h00) begin bad++; $display("FAIL abort_char_after got=%h exp=00", char); end
        send_frame(8'h4E, 1'b1);
        idle(4);
        total++; if (char !== 8'h4E) begin bad++; $display("FAIL abort_next_char got=%h exp=4e", char); end
        total++; if (cv_cnt - cv0 !== 1) begin bad++; $display("FAIL abort_next_cv got=%0d exp=1", cv_cnt - cv0); end
        total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL abort_fe got=%0d exp=0", fe_cnt - fe0); end
    endtask

`ifdef SMART_HOUSE_UART_PARITY_EN
    task automatic test_parity();
        int cv0 = cv_cnt;
        int pe0 = pe_cnt;
        int fe0 = fe_cnt;
        par_flip = 1'b0;
        send_frame(8'h4F, 1'b1);
        idle(4);
        total++; if (char !== 8'h4F) begin bad++; $display("FAIL par_good_char got=%h exp=4f", char); end
        total++; if (cv_cnt - cv0 !== 1) begin bad++; $display("FAIL par_good_cv got=%0d exp=1", cv_cnt - cv0); end
        total++; if (pe_cnt - pe0 !== 0) begin bad++; $display("FAIL par_good_pe got=%0d exp=0", pe_cnt - pe0); end
        par_flip = 1'b1;
        send_frame(8'h45, 1'b1);
        idle(4);
        total++; if (pe_cnt - pe0 !== 1) begin bad++; $display("FAIL par_bad_pe got=%0d exp=1", pe_cnt - pe0); end
        total++; if (cv_cnt - cv0 !== 1) begin bad++; $display("FAIL par_bad_cv got=%0d exp=1", cv_cnt - cv0); end
        total++; if (char !== 8'h4F) begin bad++; $display("FAIL par_bad_char got=%h exp=4f", char); end
        send_frame(8'h45, 1'b0);
        idle(10);
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL par_stop_fe got=%0d exp=1", fe_cnt - fe0); end
        total++; if (pe_cnt - pe0 !== 1) begin bad++; $display("FAIL par_stop_pe got=%0d exp=1", pe_cnt - pe0); end
        par_flip = 1'b0;
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL par_overlap got=%0d exp=0", both_cnt); end
    endtask
`endif

    initial begin
        reset = 1'b0;
        rx    = 1'b1;
        @(negedge clock);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_abort();
`ifdef SMART_HOUSE_UART_PARITY_EN
        test_parity();
`endif
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL final_overlap got=%0d exp=0", both_cnt); end
        total++; if (cvbusy_cnt !== 0) begin bad++; $display("FAIL final_cv_busy got=%0d exp=0", cvbusy_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/smart_house_uart_rx.md
Name: smart_house_uart_rx

Overview:
- Serial command receiver for the SmartHouse controller.
- Deserialises an asynchronous 8N1 UART line into bytes.
- Presents each byte on `char` with a one-cycle `char_valid` strobe.
- Sits directly upstream of the character-recognition FSM, which consumes `char`/`char_valid` to detect command words such as "OPENWINDOW".

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Legal range is 4 or more. The counter width is $clog2(CLKS_PER_BIT).

Ports:
- clock  input  1  system clock; all logic on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- rx  input  1  raw serial line; idles high; asynchronous to clock
- char  output  8  last correctly received byte; held until the next good byte
- char_valid  output  1  one-cycle pulse: `char` was updated this cycle
- frame_error  output  1  one-cycle pulse: the stop bit sampled 0
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Input sync:
  - rx passes through 2 flip-flops before use (rx_s).
  - Both flops reset to 1.
  - Only rx_s is used internally.
- Reset values: char=8'h00, char_valid=0, frame_error=0, busy=0, state=IDLE, counters=0, shift register=0.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH (plus PARITY when the optional feature is enabled).
- IDLE:
  - If rx_s==0, go to START with the bit counter cleared.
  - Otherwise stay in IDLE.
- START:
  - Count to CLKS_PER_BIT/2-1 (integer divide), then sample rx_s.
  - If the sample is 0, this is a valid start bit: go to DATA, clear the counter, set bit_index=0.
  - If the sample is 1, this is a glitch: return to IDLE with no outputs.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rx_s into shift[bit_index] (LSB first) and clear the counter.
  - After bit_index 7, go to STOP; otherwise increment bit_index.
  - All sample points are therefore mid-bit.
- STOP: count to CLKS_PER_BIT-1, then sample rx_s.
  - Sample = 1: on the next clock, char<=shift, char_valid=1 for exactly one cycle, go to IDLE.
  - Sample = 0: frame_error=1 for one cycle, char unchanged, char_valid stays 0, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s==1, then go to IDLE.
  - This prevents a break condition or a stuck-low line from generating repeated frames or errors.
- Back-to-back frames: a new start bit detected in the first IDLE cycle after STOP is accepted. No idle gap is required beyond the stop bit.
- Simultaneity:
  - char_valid and frame_error are never high in the same cycle.
  - busy is low in the cycle char_valid is high.
- Reset mid-frame: the asynchronous reset aborts the frame immediately and all registers return to their reset values. The partial byte is discarded; no strobe is issued.
- Downstream contract: the consumer must advance only when char_valid=1. char is stable between strobes.

Optional Feature:
- Macro: SMART_HOUSE_UART_PARITY_EN
- With the macro defined:
  - The frame is 8E1. A PARITY state sits between DATA and STOP and samples the 9th bit mid-bit.
  - Add output port parity_error (1 bit, reset 0). It pulses for one cycle, in the slot where char_valid would fire, when the XOR of the 8 data bits and the parity bit is 1.
  - On parity failure, char is not updated and char_valid is not pulsed.
  - A stop-bit failure takes priority: frame_error only, parity_error stays 0.
- Without the macro: the frame is 8N1, there is no PARITY state, and there is no parity_error port.

Test Plan (CLKS_PER_BIT=8 unless noted):
- Reset released, send 0x4F ('O') 8N1 → exactly one char_valid pulse with char=0x4F; frame_error never high; busy low afterwards.
- Send "OPEN" back-to-back with no idle gap → four char_valid pulses, char = 0x4F, 0x50, 0x45, 0x4E in order, spaced 10 bit-times (80 clocks) apart.
- Drive rx low for 2 clocks then high → busy pulses briefly; no char_valid, no frame_error; char unchanged.
- Send 0x57 with stop bit = 0, then hold rx low for 30 clocks → a single frame_error pulse; char keeps its previous value; no further events until rx returns high, after which 0x44 ('D') is received normally.
- Assert reset at data bit 4 of 0x49, release, then send 0x4E → no strobe for the aborted byte; char=0x00 after reset, then char=0x4E with one char_valid pulse.
- With SMART_HOUSE_UART_PARITY_EN: send 0x4F with parity bit 1 (correct even parity) → char_valid, char=0x4F. Send 0x4F with parity bit 0 → parity_error pulse, no char_valid, char unchanged.
